// File: rtl/spu_fwd_pkg.sv
// Shared types and helpers for the SPU result-staging / forwarding network.
// Entry field widths come from the constants below; the pipeline modules
// take their lane count, depth and port count as parameters.
package spu_fwd_pkg;

    localparam int SPU_NUM_LANES   = 2;
    localparam int SPU_DEPTH       = 8;
    localparam int SPU_DATA_W      = 128;
    localparam int SPU_ADDR_W      = 7;
    localparam int SPU_UID_W       = 3;
    localparam int SPU_NUM_RD      = 3;
    localparam int SPU_FLUSH_DEPTH = 3;
    localparam int STG_W           = $clog2(SPU_DEPTH + 1);

    // Width of the forwarding candidate vector; NUM_LANES*DEPTH must fit.
    localparam int PRIO_N  = 64;
    localparam int PRIO_IW = $clog2(PRIO_N);

    typedef struct packed {
        logic                  valid;
        logic [SPU_UID_W-1:0]  uid;
        logic                  wr_en;
        logic [SPU_ADDR_W-1:0] addr;
        logic [SPU_DATA_W-1:0] data;
    } fwd_entry_t;

    // Index of the lowest set request bit (0 when none is set).
    function automatic logic [PRIO_IW-1:0] prio_first(input logic [PRIO_N-1:0] req);
        logic [PRIO_IW-1:0] idx;
        idx = '0;
        for (int i = PRIO_N - 1; i >= 0; i--) begin
            if (req[i]) idx = PRIO_IW'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/spu_fwd_lane.sv
// One issue lane of the staging pipe: a DEPTH-entry shift register.
// Results are injected directly at their completion stage; an entry already
// shifting into that stage is older and wins (the injection is dropped and
// reported as a collision). Flush kills stages 1..FLUSH_DEPTH, stall holds.
module spu_fwd_lane
    import spu_fwd_pkg::*;
#(
    parameter int DEPTH       = SPU_DEPTH,
    parameter int FLUSH_DEPTH = SPU_FLUSH_DEPTH,
    parameter int SW          = STG_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          flush,
    input  logic [SW-1:0] in_stage,
    input  fwd_entry_t    in_ent,
    output fwd_entry_t    stg_o [DEPTH],
    output logic          collision,
    output logic          stage_err
);

    fwd_entry_t stg_q [DEPTH];
    fwd_entry_t stg_d [DEPTH];
    logic       collision_q, collision_d;
    logic       stage_err_q, stage_err_d;
    logic       inj_ok;
    logic       in_range;

    // Next-state: shift, inject, then apply stall hold and flush kill.
    always_comb begin
        collision_d = 1'b0;
        stage_err_d = 1'b0;
        inj_ok      = in_ent.valid && !stall;
        in_range    = (in_stage != '0) && (in_stage <= SW'(DEPTH));
        stg_d[0]    = '0;
        for (int s = 1; s < DEPTH; s++) stg_d[s] = stg_q[s-1];
        if (inj_ok && !in_range) stage_err_d = 1'b1;
        for (int s = 0; s < DEPTH; s++) begin
            if (inj_ok && in_range && (in_stage == SW'(s + 1))) begin
                if (stg_d[s].valid) begin
                    // A collision into a stage being flushed is moot.
                    if (!(flush && (s < FLUSH_DEPTH))) collision_d = 1'b1;
                end else begin
                    stg_d[s]       = in_ent;
                    stg_d[s].valid = 1'b1;
                end
            end
        end
        if (stall) begin
            for (int s = 0; s < DEPTH; s++) stg_d[s] = stg_q[s];
        end
        if (flush) begin
            for (int s = 0; (s < FLUSH_DEPTH) && (s < DEPTH); s++) stg_d[s].valid = 1'b0;
        end
    end

    // Stage registers and event pulses; reset clears every entry at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < DEPTH; s++) stg_q[s] <= '0;
            collision_q <= 1'b0;
            stage_err_q <= 1'b0;
        end else begin
            for (int s = 0; s < DEPTH; s++) stg_q[s] <= stg_d[s];
            collision_q <= collision_d;
            stage_err_q <= stage_err_d;
        end
    end

    assign stg_o     = stg_q;
    assign collision = collision_q;
    assign stage_err = stage_err_q;

endmodule

// File: rtl/spu_fwd_pipe.sv
// N-issue result-staging and forwarding network. Each lane owns a staging
// shift register; the last stage drives writeback directly. Operands are
// forwarded from the youngest matching staged result (lowest stage, then
// highest lane), including the entry being written back this cycle.
// Optional statistics counters: define SPU_FWD_STATS_EN.
module spu_fwd_pipe
    import spu_fwd_pkg::*;
#(
    parameter int NUM_LANES   = SPU_NUM_LANES,
    parameter int DEPTH       = SPU_DEPTH,
    parameter int NUM_RD      = SPU_NUM_RD,
    parameter int FLUSH_DEPTH = SPU_FLUSH_DEPTH
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   stall,
    input  logic                                   flush,
    input  logic [NUM_LANES-1:0]                   in_valid,
    input  logic [NUM_LANES*$clog2(DEPTH+1)-1:0]   in_stage,
    input  logic [NUM_LANES-1:0]                   in_wr_en,
    input  logic [NUM_LANES*SPU_UID_W-1:0]         in_uid,
    input  logic [NUM_LANES*SPU_ADDR_W-1:0]        in_addr,
    input  logic [NUM_LANES*SPU_DATA_W-1:0]        in_data,
    output logic [NUM_LANES-1:0]                   in_ready,
    output logic [NUM_LANES-1:0]                   collision,
    output logic [NUM_LANES-1:0]                   stage_err,
    input  logic [NUM_LANES*NUM_RD*SPU_ADDR_W-1:0] rd_addr,
    input  logic [NUM_LANES*NUM_RD*SPU_DATA_W-1:0] rf_data,
    output logic [NUM_LANES*NUM_RD*SPU_DATA_W-1:0] fw_data,
    output logic [NUM_LANES*NUM_RD-1:0]            fw_hit,
    output logic [NUM_LANES-1:0]                   wb_en,
    output logic [NUM_LANES*SPU_ADDR_W-1:0]        wb_addr,
    output logic [NUM_LANES*SPU_DATA_W-1:0]        wb_data
`ifdef SPU_FWD_STATS_EN
    ,
    output logic [NUM_LANES*32-1:0]                stat_collisions,
    output logic [31:0]                            stat_fw_hits,
    output logic [NUM_LANES*32-1:0]                stat_wb
`endif
);

    localparam int SW     = $clog2(DEPTH + 1);
    localparam int ADDR_W = SPU_ADDR_W;
    localparam int DATA_W = SPU_DATA_W;
    localparam int UID_W  = SPU_UID_W;

    fwd_entry_t             lane_stg [NUM_LANES][DEPTH];
    fwd_entry_t             cand [PRIO_N];
    logic [PRIO_N-1:0]      req;
    logic [PRIO_IW-1:0]     sel;
    logic [ADDR_W-1:0]      ra;
    fwd_entry_t             wb_top;

    assign in_ready = {NUM_LANES{!stall && !flush}};

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        fwd_entry_t inj;
        assign inj = '{valid: in_valid[l],
                       uid:   in_uid[l*UID_W +: UID_W],
                       wr_en: in_wr_en[l],
                       addr:  in_addr[l*ADDR_W +: ADDR_W],
                       data:  in_data[l*DATA_W +: DATA_W]};
        spu_fwd_lane #(.DEPTH(DEPTH), .FLUSH_DEPTH(FLUSH_DEPTH), .SW(SW)) u_lane (
            .clk       (clk),
            .reset     (reset),
            .stall     (stall),
            .flush     (flush),
            .in_stage  (in_stage[l*SW +: SW]),
            .in_ent    (inj),
            .stg_o     (lane_stg[l]),
            .collision (collision[l]),
            .stage_err (stage_err[l])
        );
    end

    // Forwarding: candidates ordered by stage, then by descending lane.
    always_comb begin
        fw_data = '0;
        fw_hit  = '0;
        req     = '0;
        sel     = '0;
        ra      = '0;
        for (int c = 0; c < PRIO_N; c++) cand[c] = '0;
        for (int s = 0; s < DEPTH; s++) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                cand[s*NUM_LANES + (NUM_LANES - 1 - l)] = lane_stg[l][s];
            end
        end
        for (int p = 0; p < NUM_LANES*NUM_RD; p++) begin
            ra = rd_addr[p*ADDR_W +: ADDR_W];
            for (int c = 0; c < PRIO_N; c++) begin
                req[c] = cand[c].valid && cand[c].wr_en && (cand[c].addr == ra);
            end
            sel       = prio_first(req);
            fw_hit[p] = |req;
            fw_data[p*DATA_W +: DATA_W] = (|req) ? cand[sel].data : rf_data[p*DATA_W +: DATA_W];
        end
    end

    // Writeback from the last stage; a younger lane to the same register wins.
    always_comb begin
        wb_en   = '0;
        wb_addr = '0;
        wb_data = '0;
        wb_top  = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            wb_top = lane_stg[l][DEPTH-1];
            wb_addr[l*ADDR_W +: ADDR_W] = wb_top.addr;
            wb_data[l*DATA_W +: DATA_W] = wb_top.data;
            wb_en[l] = !stall && wb_top.valid && wb_top.wr_en;
            for (int m = l + 1; m < NUM_LANES; m++) begin
                if (lane_stg[m][DEPTH-1].valid && lane_stg[m][DEPTH-1].wr_en &&
                    (lane_stg[m][DEPTH-1].addr == wb_top.addr)) wb_en[l] = 1'b0;
            end
        end
    end

`ifdef SPU_FWD_STATS_EN
    logic [NUM_LANES*32-1:0] stat_col_q, stat_col_d;
    logic [NUM_LANES*32-1:0] stat_wb_q, stat_wb_d;
    logic [31:0]             stat_fw_q, stat_fw_d;
    logic [31:0]             hit_cnt;
    logic [32:0]             fw_sum;

    // Saturating event counters.
    always_comb begin
        stat_col_d = stat_col_q;
        stat_wb_d  = stat_wb_q;
        hit_cnt    = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (collision[l] && (stat_col_q[l*32 +: 32] != '1))
                stat_col_d[l*32 +: 32] = stat_col_q[l*32 +: 32] + 32'd1;
            if (wb_en[l] && (stat_wb_q[l*32 +: 32] != '1))
                stat_wb_d[l*32 +: 32] = stat_wb_q[l*32 +: 32] + 32'd1;
        end
        for (int p = 0; p < NUM_LANES*NUM_RD; p++) hit_cnt = hit_cnt + 32'(fw_hit[p]);
        fw_sum    = {1'b0, stat_fw_q} + {1'b0, hit_cnt};
        stat_fw_d = stall ? stat_fw_q : (fw_sum[32] ? '1 : fw_sum[31:0]);
    end

    // Counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_col_q <= '0;
            stat_wb_q  <= '0;
            stat_fw_q  <= '0;
        end else begin
            stat_col_q <= stat_col_d;
            stat_wb_q  <= stat_wb_d;
            stat_fw_q  <= stat_fw_d;
        end
    end

    assign stat_collisions = stat_col_q;
    assign stat_wb         = stat_wb_q;
    assign stat_fw_hits    = stat_fw_q;
`endif

endmodule

// File: tb/tb_spu_fwd_pipe.sv
// Directed bench for spu_fwd_pipe at default parameters
// (2 lanes, depth 8, 128-bit data, 3 read ports, flush depth 3).
module tb_spu_fwd_pipe;

    localparam int NL = 2;
    localparam int NR = 3;
    localparam int DW = 128;
    localparam int AW = 7;
    localparam int UW = 3;
    localparam int SW = 4;

    localparam logic [DW-1:0] D_A5 = {16{8'hA5}};
    localparam logic [DW-1:0] D_C2 = {16{8'hC2}};
    localparam logic [DW-1:0] D_C3 = {16{8'hC3}};
    localparam logic [DW-1:0] D_11 = {16{8'h11}};
    localparam logic [DW-1:0] D_22 = {16{8'h22}};
    localparam logic [DW-1:0] D_33 = {16{8'h33}};
    localparam logic [DW-1:0] D_E5 = {16{8'hE5}};
    localparam logic [DW-1:0] D_E2 = {16{8'hE2}};
    localparam logic [DW-1:0] D_F7 = {16{8'hF7}};
    localparam logic [DW-1:0] D_F8 = {16{8'hF8}};
    localparam logic [DW-1:0] D_GG = {16{8'h5A}};

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  stall;
    logic                  flush;
    logic [NL-1:0]         in_valid;
    logic [NL*SW-1:0]      in_stage;
    logic [NL-1:0]         in_wr_en;
    logic [NL*UW-1:0]      in_uid;
    logic [NL*AW-1:0]      in_addr;
    logic [NL*DW-1:0]      in_data;
    logic [NL-1:0]         in_ready;
    logic [NL-1:0]         collision;
    logic [NL-1:0]         stage_err;
    logic [NL*NR*AW-1:0]   rd_addr;
    logic [NL*NR*DW-1:0]   rf_data;
    logic [NL*NR*DW-1:0]   fw_data;
    logic [NL*NR-1:0]      fw_hit;
    logic [NL-1:0]         wb_en;
    logic [NL*AW-1:0]      wb_addr;
    logic [NL*DW-1:0]      wb_data;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Clock and DUT
    always #5 clk = ~clk;

    spu_fwd_pipe dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_stage  (in_stage),
        .in_wr_en  (in_wr_en),
        .in_uid    (in_uid),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .collision (collision),
        .stage_err (stage_err),
        .rd_addr   (rd_addr),
        .rf_data   (rf_data),
        .fw_data   (fw_data),
        .fw_hit    (fw_hit),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data)
    );

    // Comparison helper
    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic inj(input int l, input int stg, input logic [AW-1:0] a, input logic [DW-1:0] d);
        in_valid[l]            = 1'b1;
        in_stage[l*SW +: SW]   = SW'(stg);
        in_wr_en[l]            = 1'b1;
        in_uid[l*UW +: UW]     = UW'(l + 1);
        in_addr[l*AW +: AW]    = a;
        in_data[l*DW +: DW]    = d;
    endtask

    task automatic clr_inj();
        in_valid = '0;
        in_stage = '0;
        in_wr_en = '0;
        in_addr  = '0;
        in_data  = '0;
    endtask

    task automatic set_rd(input int l, input int p, input logic [AW-1:0] a);
        rd_addr[(l*NR+p)*AW +: AW] = a;
    endtask

    task automatic clr_rd();
        rd_addr = {(NL*NR){7'h7F}};
    endtask

    function automatic logic [DW-1:0] fwd(input int l, input int p);
        return fw_data[(l*NR+p)*DW +: DW];
    endfunction

    function automatic logic [DW-1:0] rfw(input int l, input int p);
        return rf_data[(l*NR+p)*DW +: DW];
    endfunction

    // Directed sequence
    initial begin
        reset  = 1'b0;
        stall  = 1'b0;
        flush  = 1'b0;
        in_uid = '0;
        clr_inj();
        clr_rd();
        for (int i = 0; i < NL*NR; i++) rf_data[i*DW +: DW] = {16{8'(8'hF0 + i)}};

        // Reset state
        cyc();
        cyc();
        chk("rst_wb_en", wb_en, 2'b00);
        chk("rst_wb_addr", wb_addr, '0);
        chk("rst_wb_data", wb_data, '0);
        chk("rst_collision", collision, 2'b00);
        chk("rst_stage_err", stage_err, 2'b00);
        chk("rst_fw_hit", fw_hit, '0);
        chk("rst_fw_passthru", fwd(1, 2), rfw(1, 2));
        reset = 1'b1;
        cyc();

        // Basic aging: stage 3 -> writeback six cycles later, forwarded throughout
        inj(0, 3, 7'd5, D_A5);
        set_rd(0, 0, 7'd5);
        #1;
        chk("t1_ready", in_ready, 2'b11);
        chk("t1_nohit_yet", fw_hit[0], 1'b0);
        chk("t1_rf_pass", fwd(0, 0), rfw(0, 0));
        cyc();
        clr_inj();
        for (int k = 1; k <= 5; k++) begin
            chk("t1_fw_hit", fw_hit[0], 1'b1);
            chk("t1_fw_data", fwd(0, 0), D_A5);
            chk("t1_wb_idle", wb_en, 2'b00);
            cyc();
        end
        chk("t1_wb_en", wb_en, 2'b01);
        chk("t1_wb_addr", wb_addr[AW-1:0], 7'd5);
        chk("t1_wb_data", wb_data[DW-1:0], D_A5);
        chk("t1_fw_bypass", fwd(0, 0), D_A5);
        cyc();
        chk("t1_wb_gone", wb_en, 2'b00);
        chk("t1_fw_gone", fw_hit[0], 1'b0);
        clr_rd();

        // Collision: older entry shifting into the target stage wins
        inj(0, 2, 7'd12, D_C2);
        cyc();
        inj(0, 3, 7'd13, D_C3);
        #1;
        chk("t2_col_pre", collision, 2'b00);
        cyc();
        clr_inj();
        set_rd(0, 1, 7'd13);
        set_rd(0, 2, 7'd12);
        #1;
        chk("t2_col_pulse", collision, 2'b01);
        chk("t2_dropped_nohit", fw_hit[1], 1'b0);
        chk("t2_older_hit", fwd(0, 2), D_C2);
        cyc();
        chk("t2_col_clear", collision, 2'b00);
        repeat (4) cyc();
        chk("t2_wb_en", wb_en, 2'b01);
        chk("t2_wb_addr", wb_addr[AW-1:0], 7'd12);
        chk("t2_wb_data", wb_data[DW-1:0], D_C2);
        cyc();
        chk("t2_no_second_wb", wb_en, 2'b00);
        clr_rd();

        // Same address in both lanes; lane priority, then stage priority
        inj(0, 4, 7'd9, D_11);
        inj(1, 4, 7'd9, D_22);
        cyc();
        clr_inj();
        set_rd(0, 0, 7'd9);
        set_rd(1, 2, 7'd9);
        #1;
        chk("t3_lane_prio_l0", fwd(0, 0), D_22);
        chk("t3_lane_prio_l1", fwd(1, 2), D_22);
        chk("t3_hit_bits", fw_hit, 6'b100001);
        inj(0, 2, 7'd9, D_33);
        cyc();
        clr_inj();
        #1;
        chk("t3_stage_prio", fwd(0, 0), D_33);
        repeat (3) cyc();
        chk("t3_wb_arb", wb_en, 2'b10);
        chk("t3_wb_addr1", wb_addr[AW +: AW], 7'd9);
        chk("t3_wb_data1", wb_data[DW +: DW], D_22);
        repeat (3) cyc();
        chk("t3_wb_c", wb_en, 2'b01);
        chk("t3_wb_c_data", wb_data[DW-1:0], D_33);
        cyc();
        clr_rd();

        // Flush kills young entries, deeper ones continue
        inj(0, 5, 7'd20, D_E5);
        inj(1, 2, 7'd21, D_E2);
        cyc();
        clr_inj();
        flush = 1'b1;
        #1;
        chk("t4_ready_flush", in_ready, 2'b00);
        cyc();
        flush = 1'b0;
        set_rd(0, 0, 7'd20);
        set_rd(1, 0, 7'd21);
        #1;
        chk("t4_deep_hit", fw_hit[0], 1'b1);
        chk("t4_young_gone", fw_hit[3], 1'b0);
        chk("t4_ready_back", in_ready, 2'b11);
        repeat (2) cyc();
        chk("t4_wb_en", wb_en, 2'b01);
        chk("t4_wb_addr", wb_addr[AW-1:0], 7'd20);
        for (int k = 0; k < 6; k++) begin
            cyc();
            chk("t4_no_young_wb", wb_en, 2'b00);
        end
        clr_rd();

        // Stall: hold, suppress writeback, keep forwarding, ignore injections
        inj(0, 7, 7'd30, D_F7);
        inj(1, 8, 7'd31, D_F8);
        cyc();
        clr_inj();
        stall = 1'b1;
        in_valid[1] = 1'b1;
        in_stage[SW +: SW] = 4'd0;
        set_rd(0, 0, 7'd30);
        set_rd(1, 1, 7'd31);
        #1;
        chk("t5_ready_stall", in_ready, 2'b00);
        chk("t5_wb_forced0", wb_en, 2'b00);
        chk("t5_fw_stall", fwd(0, 0), D_F7);
        chk("t5_fw_st8_stall", fwd(1, 1), D_F8);
        for (int k = 0; k < 2; k++) begin
            cyc();
            chk("t5_wb_stalled", wb_en, 2'b00);
            chk("t5_no_err_stalled", stage_err, 2'b00);
        end
        cyc();
        clr_inj();
        stall = 1'b0;
        #1;
        chk("t5_release_wb", wb_en, 2'b10);
        chk("t5_release_data", wb_data[DW +: DW], D_F8);
        cyc();
        chk("t5_wb_after", wb_en, 2'b01);
        chk("t5_wb_after_addr", wb_addr[AW-1:0], 7'd30);
        chk("t5_wb_after_data", wb_data[DW-1:0], D_F7);
        cyc();
        clr_rd();

        // Out-of-range stage index
        inj(0, 0, 7'd40, D_A5);
        inj(1, 9, 7'd41, D_A5);
        set_rd(0, 0, 7'd40);
        set_rd(1, 0, 7'd41);
        cyc();
        clr_inj();
        chk("t6_stage_err", stage_err, 2'b11);
        cyc();
        chk("t6_err_clear", stage_err, 2'b00);
        for (int k = 0; k < 8; k++) begin
            chk("t6_no_wb", wb_en, 2'b00);
            chk("t6_no_hit", fw_hit, '0);
            cyc();
        end
        clr_rd();

        // Asynchronous reset mid-flow
        inj(0, 8, 7'd50, D_GG);
        inj(1, 5, 7'd51, D_GG);
        set_rd(0, 0, 7'd50);
        cyc();
        clr_inj();
        chk("t7_wb_before", wb_en, 2'b01);
        reset = 1'b0;
        #1;
        chk("t7_wb_en_rst", wb_en, 2'b00);
        chk("t7_wb_data_rst", wb_data, '0);
        chk("t7_fw_rst", fw_hit, '0);
        cyc();
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc();
            chk("t7_no_late_wb", wb_en, 2'b00);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
